// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants and fetch-state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_pkg;

  localparam logic [3:0] OP_NOP       = 4'h0;
  localparam logic [3:0] OP_ADD       = 4'h1;
  localparam logic [3:0] OP_MOV_R_ACC = 4'h9;
  localparam logic [3:0] OP_MOV_IMM   = 4'hA;
  localparam logic [3:0] OP_HALT      = 4'hF;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch: drives imem from the PC and loads the IR for decode.
// Latency: first instruction valid one edge after reset release or redirect; one load per cycle when drained.
// Backpressure: ir_valid/ir_ready handshake; IR, ir_pc and PC hold while ir_valid=1 and ir_ready=0.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   imem_addr/imem_data   instruction memory address out, combinational read data in
//   ir_out/ir_pc/ir_valid instruction register, its address and valid flag to decode
//   ir_ready              decode takes ir_out on this edge
//   redirect_valid/_pc    flush and restart fetch at redirect_pc (highest priority)
//   halted                a HALT has been loaded and fetch has stopped
//   fetch_count           saturating count of IR loads since reset
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] ir_out,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic [ADDR_W-1:0] ir_pc_q;
  logic              ir_valid_q;
  logic              halted_q;
  logic [15:0]       fetch_count_q;

  logic              transfer;
  logic              load;
  logic              is_halt;
  logic [ADDR_W-1:0] pc_d;
  logic [15:0]       fetch_count_d;

  assign transfer = ir_valid_q & ir_ready;
  // Redirect wins over a load even when decode drains the IR on the same edge.
  assign load     = (state_q == FETCH) & (~ir_valid_q | transfer) & ~redirect_valid;
  assign is_halt  = (imem_data[DATA_W-1 -: 4] == OP_HALT);

  // A HALT leaves the PC pointing at itself so a later redirect is the only way out.
  assign pc_d          = is_halt ? pc_q : pc_q + PC_ONE;
  assign fetch_count_d = (fetch_count_q == 16'hFFFF) ? fetch_count_q : fetch_count_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= '0;
      ir_q          <= '0;
      ir_pc_q       <= '0;
      ir_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else if (redirect_valid) begin
      state_q    <= FETCH;
      pc_q       <= redirect_pc;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (load) begin
            ir_q          <= imem_data;
            ir_pc_q       <= pc_q;
            ir_valid_q    <= 1'b1;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
            if (is_halt) begin
              state_q  <= HALTED;
              halted_q <= 1'b1;
            end
          end
        end
        HALTED: begin
          // The HALT stays presented until decode takes it; nothing new is loaded.
          if (transfer) ir_valid_q <= 1'b0;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign ir_out      = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_valid    = ir_valid_q;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed vector table plus an async-reset sequence.
// Latency: n/a.
// Backpressure: n/a.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [7:0]  imem_data;
  logic [7:0]  ir_out;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halted;
  logic [15:0] fetch_count;

  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  assign imem_data = mem[imem_addr];

  fetch_stage #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .ir_out         (ir_out),
    .ir_pc          (ir_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pre_rst;
    logic        ready;
    logic        redir;
    logic [7:0]  rpc;
    logic        exp_valid;
    logic [7:0]  exp_ir;
    logic [7:0]  exp_pc;
    logic [7:0]  exp_addr;
    logic        exp_halt;
    logic [15:0] exp_cnt;
  } vec_t;

  localparam int NV = 29;
  vec_t tab [NV];

  function automatic vec_t mk(logic pr, logic rdy, logic rd, logic [7:0] rp,
                              logic ev, logic [7:0] ei, logic [7:0] ep,
                              logic [7:0] ea, logic eh, logic [15:0] ec);
    vec_t v;
    v.pre_rst = pr;  v.ready = rdy; v.redir = rd;   v.rpc = rp;
    v.exp_valid = ev; v.exp_ir = ei; v.exp_pc = ep; v.exp_addr = ea;
    v.exp_halt = eh; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'hA3; mem[1] = 8'h91; mem[2] = 8'hA5;
    mem[3] = 8'h11; mem[4] = 8'h00; mem[5] = 8'hF0;
    mem[8'hFF] = 8'h00;

    // Program run with ir_ready=1, halt, then drain of the HALT
    tab[0]  = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'hA3,8'h00,8'h01,1'b0,16'd1);
    tab[1]  = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'h91,8'h01,8'h02,1'b0,16'd2);
    tab[2]  = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'hA5,8'h02,8'h03,1'b0,16'd3);
    tab[3]  = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'h11,8'h03,8'h04,1'b0,16'd4);
    tab[4]  = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'h00,8'h04,8'h05,1'b0,16'd5);
    tab[5]  = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'hF0,8'h05,8'h05,1'b1,16'd6);
    tab[6]  = mk(1'b0,1'b1,1'b0,8'h00, 1'b0,8'hF0,8'h05,8'h05,1'b1,16'd6);
    tab[7]  = mk(1'b0,1'b1,1'b0,8'h00, 1'b0,8'hF0,8'h05,8'h05,1'b1,16'd6);
    // Reset, then stall 3 cycles after first load
    tab[8]  = mk(1'b1,1'b0,1'b0,8'h00, 1'b1,8'hA3,8'h00,8'h01,1'b0,16'd1);
    tab[9]  = mk(1'b0,1'b0,1'b0,8'h00, 1'b1,8'hA3,8'h00,8'h01,1'b0,16'd1);
    tab[10] = mk(1'b0,1'b0,1'b0,8'h00, 1'b1,8'hA3,8'h00,8'h01,1'b0,16'd1);
    tab[11] = mk(1'b0,1'b0,1'b0,8'h00, 1'b1,8'hA3,8'h00,8'h01,1'b0,16'd1);
    tab[12] = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'h91,8'h01,8'h02,1'b0,16'd2);
    tab[13] = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'hA5,8'h02,8'h03,1'b0,16'd3);
    // Redirect to 3 while IR holds A5
    tab[14] = mk(1'b0,1'b0,1'b1,8'h03, 1'b0,8'hA5,8'h02,8'h03,1'b0,16'd3);
    tab[15] = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'h11,8'h03,8'h04,1'b0,16'd4);
    // Redirect coincident with a transfer: flush, no load
    tab[16] = mk(1'b0,1'b1,1'b1,8'h00, 1'b0,8'h11,8'h03,8'h00,1'b0,16'd4);
    tab[17] = mk(1'b0,1'b0,1'b0,8'h00, 1'b1,8'hA3,8'h00,8'h01,1'b0,16'd5);
    // Redirect to FF, PC wraps to 00
    tab[18] = mk(1'b0,1'b0,1'b1,8'hFF, 1'b0,8'hA3,8'h00,8'hFF,1'b0,16'd5);
    tab[19] = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'h00,8'hFF,8'h00,1'b0,16'd6);
    tab[20] = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'hA3,8'h00,8'h01,1'b0,16'd7);
    tab[21] = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'h91,8'h01,8'h02,1'b0,16'd8);
    tab[22] = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'hA5,8'h02,8'h03,1'b0,16'd9);
    tab[23] = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'h11,8'h03,8'h04,1'b0,16'd10);
    tab[24] = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'h00,8'h04,8'h05,1'b0,16'd11);
    tab[25] = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'hF0,8'h05,8'h05,1'b1,16'd12);
    // Halted with decode stalled: HALT stays presented
    tab[26] = mk(1'b0,1'b0,1'b0,8'h00, 1'b1,8'hF0,8'h05,8'h05,1'b1,16'd12);
    // Redirect out of HALTED to 0
    tab[27] = mk(1'b0,1'b0,1'b1,8'h00, 1'b0,8'hF0,8'h05,8'h00,1'b0,16'd12);
    tab[28] = mk(1'b0,1'b1,1'b0,8'h00, 1'b1,8'hA3,8'h00,8'h01,1'b0,16'd13);

    rst_n          = 1'b0;
    ir_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst ir_valid",    32'(ir_valid),    32'h0);
    chk("rst imem_addr",   32'(imem_addr),   32'h0);
    chk("rst ir_out",      32'(ir_out),      32'h0);
    chk("rst ir_pc",       32'(ir_pc),       32'h0);
    chk("rst halted",      32'(halted),      32'h0);
    chk("rst fetch_count", 32'(fetch_count), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      if (tab[i].pre_rst) pulse_reset();
      ir_ready       = tab[i].ready;
      redirect_valid = tab[i].redir;
      redirect_pc    = tab[i].rpc;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d ir_valid", i),    32'(ir_valid),    32'(tab[i].exp_valid));
      chk($sformatf("v%0d ir_out", i),      32'(ir_out),      32'(tab[i].exp_ir));
      chk($sformatf("v%0d ir_pc", i),       32'(ir_pc),       32'(tab[i].exp_pc));
      chk($sformatf("v%0d imem_addr", i),   32'(imem_addr),   32'(tab[i].exp_addr));
      chk($sformatf("v%0d halted", i),      32'(halted),      32'(tab[i].exp_halt));
      chk($sformatf("v%0d fetch_count", i), 32'(fetch_count), 32'(tab[i].exp_cnt));
    end

    // Asynchronous reset mid-stream while an instruction is held
    ir_ready       = 1'b0;
    redirect_valid = 1'b0;
    chk("pre-arst ir_valid", 32'(ir_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst ir_valid",    32'(ir_valid),    32'h0);
    chk("arst imem_addr",   32'(imem_addr),   32'h0);
    chk("arst fetch_count", 32'(fetch_count), 32'h0);
    chk("arst halted",      32'(halted),      32'h0);
    @(negedge clk);
    rst_n    = 1'b1;
    ir_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post-arst ir_valid",    32'(ir_valid),    32'h1);
    chk("post-arst ir_out",      32'(ir_out),      32'hA3);
    chk("post-arst ir_pc",       32'(ir_pc),       32'h0);
    chk("post-arst fetch_count", 32'(fetch_count), 32'h1);
    chk("post-arst imem_addr",   32'(imem_addr),   32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ADDR_W, default 8, program counter and instruction-address width.
REQ-002 Parameter DATA_W, default 8, instruction width; the upper 4 bits are the opcode and the lower 4 bits are the operand.
REQ-003 Port clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port imem_addr  output  ADDR_W  address driven to the instruction memory.
REQ-006 Port imem_data  input  DATA_W  instruction memory read data, valid combinationally in the same cycle as imem_addr.
REQ-007 Port ir_out  output  DATA_W  instruction register presented to decode.
REQ-008 Port ir_pc  output  ADDR_W  address of the instruction held in ir_out.
REQ-009 Port ir_valid  output  1  ir_out/ir_pc hold an instruction not yet taken by decode.
REQ-010 Port ir_ready  input  1  decode accepts ir_out this cycle.
REQ-011 Port redirect_valid  input  1  one-cycle request to restart fetch at redirect_pc.
REQ-012 Port redirect_pc  input  ADDR_W  redirect target address.
REQ-013 Port halted  output  1  fetch has stopped after loading a HALT.
REQ-014 Port fetch_count  output  16  number of instructions loaded into the IR since reset, saturating.

Function
REQ-015 imem_addr SHALL equal the internal PC register at all times, with no added combinational path from other inputs.
REQ-016 Handshake: a transfer SHALL occur on a clock edge where ir_valid=1 and ir_ready=1; ir_out/ir_pc SHALL stay stable while ir_valid=1 and ir_ready=0.
REQ-017 State FETCH, load condition (ir_valid=0 or transfer): IR<=imem_data, ir_pc<=PC, ir_valid<=1, PC<=PC+1 modulo 2^ADDR_W, so 8'hFF wraps to 8'h00.
REQ-018 State FETCH, no load condition (ir_valid=1 and ir_ready=0): PC, IR and ir_valid SHALL hold.
REQ-019 Throughput: with ir_ready held at 1, one instruction SHALL be loaded every cycle; the first ir_valid SHALL appear 1 cycle after reset release.
REQ-020 When a loaded instruction has opcode 4'hF (HALT), the state SHALL go FETCH->HALTED on that same edge, and PC SHALL NOT increment.
REQ-021 State HALTED: no further loads; PC is frozen; halted=1; the HALT instruction SHALL remain presented until a transfer, after which ir_valid=0.
REQ-022 Redirect has highest priority, from either state: ir_valid<=0 (flush), PC<=redirect_pc, state<=FETCH, halted<=0; the first redirected instruction SHALL be valid on the following edge.
REQ-023 Redirect coincident with a transfer: the transfer SHALL count as completed (decode keeps the instruction), the IR is flushed, and no load occurs that cycle.
REQ-024 fetch_count SHALL increment by 1 on every load and saturate at 16'hFFFF; redirect SHALL NOT clear it.
REQ-025 ir_ready while ir_valid=0 SHALL have no effect.

Reset
REQ-026 While rst_n=0: PC=0, IR=8'h00, ir_pc=0, ir_valid=0, halted=0, fetch_count=0, state=FETCH.
REQ-027 Reset asserted mid-operation SHALL discard any held instruction immediately, without waiting for a clock edge.
REQ-028 After rst_n deasserts, fetch SHALL begin at address 0 on the first rising edge.

Structure
REQ-029 The shared package cpu_pkg SHALL hold the opcode constants (OP_NOP=4'h0, OP_ADD=4'h1, OP_MOV_R_ACC=4'h9, OP_MOV_IMM=4'hA, OP_HALT=4'hF) and the fetch-state enum {FETCH, HALTED}.
REQ-030 fetch_stage SHALL contain no sub-module; the instruction memory SHALL be instantiated alongside it at CPU top level and connected through imem_addr/imem_data.

Verification
REQ-031 Program A3,91,A5,11,00,F0 at addresses 0-5 with ir_ready=1 -> ir_out sequence A3,91,A5,11,00,F0 on consecutive cycles with ir_pc 0..5; halted=1 from the F0 load; PC frozen at 5; fetch_count=6.
REQ-032 Same program, ir_ready=0 for 3 cycles after the first load -> ir_out holds A3 with ir_pc=0 for 3 cycles; no PC advance; sequence then resumes unchanged.
REQ-033 redirect_valid=1 with redirect_pc=3 while the IR holds A5 (pc 2) -> IR flushed; next ir_out=11 with ir_pc=3.
REQ-034 redirect_pc=8'hFF with memory[FF]=00 and memory[00]=A3 -> ir_pc FF then 00 (wrap-around); ir_out 00 then A3.
REQ-035 In HALTED, redirect_pc=0 -> halted drops on the next edge; fetch restarts with A3 at ir_pc=0.
REQ-036 rst_n pulsed low mid-stream with ir_valid=1 -> ir_valid=0 immediately; after release the first load is from address 0; fetch_count restarts at 0.
